// File: rtl/rf_wr_arbiter.sv
// Write-port arbiter/sequencer for the 32x32 register file: CPU writeback, buffered
// debug channel and a r1..r31 clear sequencer. Optional stall statistic: ARB_STATS_EN.
module rf_wr_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_waddr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          dbg_valid,
  output logic          dbg_ready,
  input  logic [AW-1:0] dbg_waddr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [15:0]   dbg_stall_cnt
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned NREG = 1 << AW;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} clr_state_t;

  clr_state_t      state, state_nxt;
  logic [AW-1:0]   ptr, ptr_nxt;
  logic [NREG-1:0] mask, mask_nxt;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          fifo_full, fifo_empty, push, pop;

  logic          grant, clr_grant;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign dbg_ready  = !fifo_full;
  assign push       = dbg_valid && dbg_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PW-1:0]] <= dbg_waddr;
      fifo_data[wr_ptr[PW-1:0]] <= dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_comb begin
    grant     = 1'b0;
    clr_grant = 1'b0;
    pop       = 1'b0;
    g_addr    = '0;
    g_data    = '0;
    if (cpu_we) begin
      grant  = 1'b1;
      g_addr = cpu_waddr;
      g_data = cpu_wdata;
    end else if (!fifo_empty) begin
      grant  = 1'b1;
      pop    = 1'b1;
      g_addr = fifo_addr[rd_ptr[PW-1:0]];
      g_data = fifo_data[rd_ptr[PW-1:0]];
    end else if (state == SCAN && !mask[ptr]) begin
      grant     = 1'b1;
      clr_grant = 1'b1;
      g_addr    = ptr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      mask  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      mask  <= mask_nxt;
    end
  end

  // The skip test reads the pre-update mask; a write landing on ptr this cycle
  // causes a hold now and a skip next cycle.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mask_nxt  = mask;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = SCAN;
          ptr_nxt   = AW'(1);
          mask_nxt  = '0;
        end
      end
      SCAN: begin
        if (grant && !clr_grant) mask_nxt[g_addr] = 1'b1;
        if (mask[ptr] || clr_grant) begin
          if (ptr == '1) state_nxt = DONE;
          else           ptr_nxt   = ptr + AW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_busy = (state == SCAN);
  assign clr_done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant && (g_addr != '0);
      if (grant) begin
        rf_waddr <= g_addr;
        rf_wdata <= g_data;
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           dbg_stall_cnt <= '0;
    else if (!fifo_empty && cpu_we && dbg_stall_cnt != '1) dbg_stall_cnt <= dbg_stall_cnt + 16'd1;
  end
`else
  assign dbg_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: a queue-based reference model predicts each
// cycle's outputs; a negedge monitor pops and compares.
module tb_rf_wr_arbiter;

  localparam int unsigned FIFO_DEPTH = 2;

  logic        clk, rst;
  logic        cpu_we;
  logic [4:0]  cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        dbg_valid, dbg_ready;
  logic [4:0]  dbg_waddr;
  logic [31:0] dbg_wdata;
  logic        clr_start, clr_busy, clr_done;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] dbg_stall_cnt;

  rf_wr_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dbg_stall_cnt(dbg_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        ready;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur;
  localparam exp_t RESET_EXP = '{we: 1'b0, addr: 5'd0, data: 32'd0, busy: 1'b0,
                                 done: 1'b0, ready: 1'b1, cnt: 16'd0};

  // Reference model: phase 0=idle, 1=scanning, 2=done pulse
  logic [36:0] m_fifo[$];
  int          m_phase, m_ptr, m_cnt;
  bit [31:0]   m_mask;
  logic [4:0]  m_la;
  logic [31:0] m_ld;

  function automatic void model_step();
    bit          w = 0, from_clr = 0, adv;
    bit          can_push;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic [36:0] ent;
    exp_t        e;
    can_push = m_fifo.size() < FIFO_DEPTH;
    if (m_fifo.size() > 0 && cpu_we && m_cnt < 65535) m_cnt++;
    if (cpu_we) begin
      w = 1; wa = cpu_waddr; wd = cpu_wdata;
    end else if (m_fifo.size() > 0) begin
      ent = m_fifo.pop_front();
      w = 1; wa = ent[36:32]; wd = ent[31:0];
    end else if (m_phase == 1 && !m_mask[m_ptr]) begin
      w = 1; wa = 5'(m_ptr); wd = 0; from_clr = 1;
    end
    if (m_phase == 0) begin
      if (clr_start) begin m_phase = 1; m_ptr = 1; m_mask = 0; end
    end else if (m_phase == 1) begin
      adv = m_mask[m_ptr] || from_clr;
      if (w && !from_clr) m_mask[wa] = 1'b1;
      if (adv) begin
        if (m_ptr == 31) m_phase = 2;
        else m_ptr++;
      end
    end else begin
      m_phase = 0;
    end
    if (dbg_valid && can_push) m_fifo.push_back({dbg_waddr, dbg_wdata});
    if (w) begin m_la = wa; m_ld = wd; end
    e.we    = w && (wa != 0);
    e.addr  = m_la;
    e.data  = m_ld;
    e.busy  = (m_phase == 1);
    e.done  = (m_phase == 2);
    e.ready = m_fifo.size() < FIFO_DEPTH;
`ifdef ARB_STATS_EN
    e.cnt   = 16'(m_cnt);
`else
    e.cnt   = 16'd0;
`endif
    exp_q.push_back(e);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_phase = 0; m_ptr = 0; m_cnt = 0; m_mask = 0; m_la = 0; m_ld = 0;
    end else begin
      model_step();
    end
  end

  int n_we, n_zero, n_busy, n_done, n_r10_zero;

  always @(negedge clk) begin
    if (!rst) exp_cur = RESET_EXP;
    else if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
    chk("rf_we", 32'(rf_we), 32'(exp_cur.we));
    chk("rf_waddr", 32'(rf_waddr), 32'(exp_cur.addr));
    chk("rf_wdata", rf_wdata, exp_cur.data);
    chk("clr_busy", 32'(clr_busy), 32'(exp_cur.busy));
    chk("clr_done", 32'(clr_done), 32'(exp_cur.done));
    chk("dbg_ready", 32'(dbg_ready), 32'(exp_cur.ready));
    chk("dbg_stall_cnt", 32'(dbg_stall_cnt), 32'(exp_cur.cnt));
    if (rf_we) begin
      n_we++;
      if (rf_wdata == 0) n_zero++;
      if (rf_wdata == 0 && rf_waddr == 5'd10) n_r10_zero++;
    end
    if (clr_busy) n_busy++;
    if (clr_done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we = 0; cpu_waddr = 0; cpu_wdata = 0;
    dbg_valid = 0; dbg_waddr = 0; dbg_wdata = 0;
    clr_start = 0;
  endtask

  task automatic clear_counts();
    n_we = 0; n_zero = 0; n_busy = 0; n_done = 0; n_r10_zero = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [36:0] items[$];
    logic        rdy;
    logic [15:0] cnt0;
    rst = 0;
    idle_inputs();
    clear_counts();

    // 1: reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      cpu_we = 1'($urandom); cpu_waddr = 5'($urandom); cpu_wdata = $urandom;
      dbg_valid = 1'($urandom); dbg_waddr = 5'($urandom); dbg_wdata = $urandom;
      clr_start = 1'($urandom);
      tick();
    end
    idle_inputs();
    rst = 1;
    tick();

    // 2: CPU latency and address-0 suppression
    cpu_we = 1; cpu_waddr = 5; cpu_wdata = 32'h0000_1234;
    tick();
    chk("t2_we", 32'(rf_we), 32'd1);
    chk("t2_addr", 32'(rf_waddr), 32'd5);
    chk("t2_data", rf_wdata, 32'h0000_1234);
    cpu_waddr = 0; cpu_wdata = 32'hFFFF_FFFF;
    tick();
    chk("t2_we_r0", 32'(rf_we), 32'd0);
    cpu_we = 0;
    repeat (2) tick();

    // 3: debug writes blocked behind a 4-cycle CPU burst
    cnt0 = dbg_stall_cnt;
    items = {{5'd3, 32'hA}, {5'd4, 32'hB}, {5'd6, 32'hC}};
    for (int c = 0; c < 12; c++) begin
      cpu_we = (c < 4); cpu_waddr = 5'(20 + c); cpu_wdata = $urandom;
      dbg_valid = (items.size() > 0);
      if (items.size() > 0) {dbg_waddr, dbg_wdata} = items[0];
      rdy = dbg_ready;
      tick();
      if (dbg_valid && rdy) void'(items.pop_front());
    end
    idle_inputs();
    chk("t3_all_accepted", 32'(items.size()), 32'd0);
`ifdef ARB_STATS_EN
    chk("t3_stall_delta", 32'(dbg_stall_cnt - cnt0), 32'd3);
`else
    chk("t3_stall_delta", 32'(dbg_stall_cnt - cnt0), 32'd0);
`endif
    tick();

    // 4: uncontended clear
    clear_counts();
    clr_start = 1;
    tick();
    clr_start = 0;
    repeat (40) tick();
    chk("t4_zero_writes", 32'(n_zero), 32'd31);
    chk("t4_busy_cycles", 32'(n_busy), 32'd31);
    chk("t4_done_pulses", 32'(n_done), 32'd1);

    // 5: CPU writes r10 on the third scan cycle
    clear_counts();
    clr_start = 1;
    tick();
    clr_start = 0;
    repeat (2) tick();
    cpu_we = 1; cpu_waddr = 10; cpu_wdata = 32'hAA;
    tick();
    cpu_we = 0;
    repeat (40) tick();
    chk("t5_zero_writes", 32'(n_zero), 32'd30);
    chk("t5_r10_zeroed", 32'(n_r10_zero), 32'd0);
    chk("t5_total_writes", 32'(n_we), 32'd31);
    chk("t5_done_pulses", 32'(n_done), 32'd1);

    // 6: asynchronous reset mid-clear with one buffered debug entry
    clr_start = 1;
    tick();
    clr_start = 0;
    repeat (14) tick();
    cpu_we = 1; cpu_waddr = 7; cpu_wdata = 32'hDEAD_0007;
    dbg_valid = 1; dbg_waddr = 3; dbg_wdata = 32'h55;
    tick();
    idle_inputs();
    chk("t6_pre_we", 32'(rf_we), 32'd1);
    chk("t6_pre_busy", 32'(clr_busy), 32'd1);
    #3 rst = 0;
    #1;
    chk("t6_async_we", 32'(rf_we), 32'd0);
    chk("t6_async_busy", 32'(clr_busy), 32'd0);
    chk("t6_async_done", 32'(clr_done), 32'd0);
    repeat (2) tick();
    rst = 1;
    clear_counts();
    repeat (6) tick();
    chk("t6_no_stale_write", 32'(n_we), 32'd0);
    chk("t6_no_done", 32'(n_done), 32'd0);

    // 7: randomized traffic
    items.delete();
    for (int c = 0; c < 400; c++) begin
      cpu_we = ($urandom_range(99) < 35);
      cpu_waddr = 5'($urandom); cpu_wdata = $urandom;
      if (items.size() == 0 && $urandom_range(1) == 1)
        items.push_back({5'($urandom), 32'($urandom)});
      dbg_valid = (items.size() > 0);
      if (items.size() > 0) {dbg_waddr, dbg_wdata} = items[0];
      else begin dbg_waddr = 0; dbg_wdata = 0; end
      clr_start = ($urandom_range(99) < 3);
      rdy = dbg_ready;
      tick();
      if (dbg_valid && rdy) void'(items.pop_front());
    end
    idle_inputs();
    repeat (50) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
Sequencer and arbiter for the single write port of the 32x32 register file (r0 hard-wired zero).
- Shares the port between three sources: CPU writeback, a buffered debug/loader write channel, and a hardware clear sequencer that zeroes r1..r31.
- Sits between the multicycle controller/debug logic and the register file's RFWr/A3/WD inputs.
- Outputs are registered.

Parameters:
FIFO_DEPTH, 2, debug write buffer depth; power of 2, >=2
DW, 32, data width
AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
cpu_we  in  1  CPU writeback request; never stalled
cpu_waddr  in  AW  CPU write address
cpu_wdata  in  DW  CPU write data
dbg_valid  in  1  debug write offered
dbg_ready  out  1  debug write accepted when valid&ready
dbg_waddr  in  AW  debug write address
dbg_wdata  in  DW  debug write data
clr_start  in  1  start clear sequence (single-cycle pulse)
clr_busy  out  1  clear sequence scanning
clr_done  out  1  one-cycle pulse at clear completion
rf_we  out  1  to RF RFWr
rf_waddr  out  AW  to RF A3
rf_wdata  out  DW  to RF WD
dbg_stall_cnt  out  16  debug stall statistic (see Optional Feature)

Behaviour:
- rst low: rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty, clear FSM IDLE, clr_busy=0, clr_done=0, mask=0, dbg_stall_cnt=0.
- dbg_ready = !fifo_full (combinational). Push on valid&ready. No bypass.
  - Debug write accepted at cycle N is eligible at N+1, reaches rf_we at N+2 at the earliest.
  - Pushed entries pop in order.
- Per-cycle grant, fixed priority: cpu_we > FIFO head > clear sequencer. Only the winner advances; the others hold.
- Output register at posedge:
  - rf_we <= grant && (grant_addr != 0).
  - rf_waddr/rf_wdata load on any grant and hold otherwise.
  - No grant -> rf_we=0.
- Write to address 0 from any source consumes its grant/pop but produces rf_we=0.
- CPU latency: exactly 1 cycle, cpu_we@N -> rf_we@N+1.
- Clear FSM states: IDLE, SCAN, DONE.
  - IDLE: clr_start -> SCAN; ptr<=1; mask<=0. clr_start while SCAN or DONE is ignored.
  - SCAN (clr_busy=1), each cycle:
    - mask[ptr] set -> skip: ptr++, no grant.
    - else clear wins the grant -> write (ptr, 0), ptr++.
    - else hold ptr.
    - Once ptr=31 has been written or skipped -> DONE. ptr never wraps.
  - DONE: clr_done=1 for one cycle -> IDLE.
- Mask: 32 bits.
  - Any CPU or debug grant in SCAN cycles sets mask[addr]; the clear never zeroes a register written after the clear started.
  - Grants in the clr_start cycle itself do not set mask; they are ordered before the clear.
- Uncontended clear: 31 SCAN cycles, 31 writes; clr_done in the cycle after the r31 write is granted.
- rst low mid-clear: abort immediately to IDLE; no clr_done; FIFO contents discarded.

Optional Feature:
Macro ARB_STATS_EN.
- Defined: dbg_stall_cnt increments each cycle FIFO is non-empty and cpu_we=1 (head blocked by CPU); saturates at 0xFFFF; cleared only by reset.
- Undefined: counter logic absent; dbg_stall_cnt tied to 0.

Test Plan:
1. Reset: hold rst low 3 cycles with random inputs -> rf_we=0, rf_waddr=0, rf_wdata=0, dbg_ready=1, clr_busy=0, clr_done=0.
2. cpu_we=1, addr 5, data 0x00001234 at cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0x00001234 at N+1. cpu_we addr 0, data 0xFFFFFFFF -> rf_we=0.
3. cpu_we high 4 cycles; debug offers (3,0xA),(4,0xB),(6,0xC) from first of those cycles:
   - dbg_ready drops after 2 accepts.
   - No debug writes while cpu_we=1.
   - After cpu_we falls: r3=0xA then r4=0xB, then r6=0xC accepted and written.
   - With ARB_STATS_EN, dbg_stall_cnt=3 (stall counted cycles 2-4 of the CPU burst; the first entry becomes visible only at cycle 2).
4. clr_start in IDLE, no traffic -> 31 consecutive rf_we writes r1..r31, data 0; clr_busy high 31 cycles; one clr_done pulse.
5. clr_start, then CPU writes r10=0xAA on SCAN cycle 3 -> r10 written 0xAA; no later zero write to r10; 30 zero writes; clr_done still pulses once.
6. rst pulled low with ptr=15 in SCAN and FIFO holding 1 entry -> rf_we=0 asynchronously; clr_busy=0; no clr_done; after release, no stale debug write.
